// File: rtl/led_matrix_scan_if.sv
// Request, ROM and matrix-display signals of the LED matrix scanner.
// master drives requests and ROM data; slave is the scanner itself.
interface led_matrix_scan_if #(
    parameter int unsigned WADDR = 4,
    parameter int unsigned WDATA = 64
);
    logic             pi_load;
    logic [WADDR-1:0] pi_digit;
    logic             po_rom_en;
    logic [WADDR-1:0] po_rom_addr;
    logic [WDATA-1:0] pi_rom_data;
    logic [7:0]       po_col;
    logic [7:0]       po_row;
    logic             po_frame_done;
    logic             po_busy;

    modport master (
        output pi_load, pi_digit, pi_rom_data,
        input  po_rom_en, po_rom_addr, po_col, po_row, po_frame_done, po_busy
    );

    modport slave (
        input  pi_load, pi_digit, pi_rom_data,
        output po_rom_en, po_rom_addr, po_col, po_row, po_frame_done, po_busy
    );
endinterface

// File: rtl/led_matrix_scan.sv
// Fetches an 8x8 glyph from a 1-cycle ROM and scans it column by column,
// double-buffered so a new glyph only takes effect at a frame boundary.
module led_matrix_scan #(
    parameter int unsigned WADDR   = 4,
    parameter int unsigned WDATA   = 64,
    parameter int unsigned CLK_DIV = 1000
) (
    input logic              pi_clk,
    input logic              pi_rst_n,
    led_matrix_scan_if.slave bus
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [WADDR-1:0] digit_q, digit_d;
    logic [WADDR-1:0] addr_q, addr_d;
    logic             busy_q, busy_d;
    logic [WDATA-1:0] frame_q, frame_d;
    logic [WDATA-1:0] shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;
    logic [2:0]       col_idx_q, col_idx_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [7:0]       col_q, col_d;
    logic [7:0]       row_q, row_d;
    logic             frame_done_q, frame_done_d;
    logic             col_tick;
    logic             boundary;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        digit_d   = digit_q;
        addr_d    = addr_q;
        case (state_q)
            StIdle:  if (pending_q) state_d = StFetch;
            StFetch: begin
                pending_d = 1'b0;
                addr_d    = digit_q;
                state_d   = StWait;
            end
            StWait:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A request in the fetch cycle keeps pending so it gets its own fetch.
        if (bus.pi_load) begin
            pending_d = 1'b1;
            digit_d   = bus.pi_digit;
        end
        busy_d = pending_d | (state_d != StIdle);
    end

    // col_idx_q is the column presented on the next tick; the first tick shows column 0.
    always_comb begin
        col_tick       = (div_q == DivW'(CLK_DIV - 1));
        boundary       = col_tick & col_q[7];
        div_d          = col_tick ? '0 : div_q + 1'b1;
        col_idx_d      = col_tick ? col_idx_q + 3'd1 : col_idx_q;
        frame_d        = frame_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        if (boundary && shadow_valid_q) begin
            frame_d        = shadow_q;
            shadow_valid_d = 1'b0;
        end
        // Capture after the swap: a same-edge capture waits for the next boundary.
        if (state_q == StWait) begin
            shadow_d       = bus.pi_rom_data;
            shadow_valid_d = 1'b1;
        end
        col_d = col_q;
        row_d = row_q;
        if (col_tick) begin
            col_d = 8'd1 << col_idx_q;
            row_d = frame_d[{col_idx_q, 3'b000} +: 8];
        end
        frame_done_d = boundary;
    end

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_q        <= StIdle;
            pending_q      <= 1'b0;
            digit_q        <= '0;
            addr_q         <= '0;
            busy_q         <= 1'b0;
            frame_q        <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            col_idx_q      <= 3'd0;
            div_q          <= '0;
            col_q          <= 8'd0;
            row_q          <= 8'd0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            digit_q        <= digit_d;
            addr_q         <= addr_d;
            busy_q         <= busy_d;
            frame_q        <= frame_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            col_idx_q      <= col_idx_d;
            div_q          <= div_d;
            col_q          <= col_d;
            row_q          <= row_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.po_rom_en     = (state_q == StFetch);
    assign bus.po_rom_addr   = (state_q == StFetch) ? digit_q : addr_q;
    assign bus.po_col        = col_q;
    assign bus.po_row        = row_q;
    assign bus.po_frame_done = frame_done_q;
    assign bus.po_busy       = busy_q;
endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Reader and display driver for the 8x8 LED digit-pattern ROM.
- On a digit request it fetches the 64-bit glyph from the ROM through its enable/address port, which has a 1-cycle registered read.
- It time-multiplexes the glyph onto an 8x8 matrix one column at a time.
- A new glyph is double-buffered and swapped only at a frame boundary, so the display never tears.

Parameters:
- WADDR, 4, ROM address width (digit code width).
- WDATA, 64, ROM data width. It is fixed at 8 columns x 8 rows; the block supports no other value.
- CLK_DIV, 1000, clock cycles each column is held (dwell). Must be >= 2.

Ports:
- pi_clk  in  1  system clock; all logic on the rising edge.
- pi_rst_n  in  1  asynchronous active-low reset.
- pi_load  in  1  one-cycle strobe: request display of pi_digit.
- pi_digit  in  WADDR  digit code, sampled when pi_load=1.
- po_rom_en  out  1  ROM read enable.
- po_rom_addr  out  WADDR  ROM address.
- pi_rom_data  in  WDATA  ROM read data, valid the cycle after po_rom_en=1.
- po_col  out  8  one-hot column select, active-high; bit k = column k.
- po_row  out  8  row data for the active column; 1 = LED on.
- po_frame_done  out  1  one-cycle pulse after column 7 dwell completes.
- po_busy  out  1  high while a fetch is pending or in progress.

Behaviour:
- Reset (async, pi_rst_n=0) clears the following, effective immediately:
  - FSM=IDLE.
  - frame, shadow and shadow_valid all 0.
  - pending=0, digit register=0.
  - column index=0, divider=0.
  - All outputs 0: po_col, po_row, po_rom_en, po_rom_addr, po_frame_done, po_busy.
- Reset mid-fetch abandons the fetch; the displayed frame becomes blank (0).
- Request capture:
  - pi_load=1 latches pi_digit into the digit register and sets pending.
  - This happens in any state.
  - A later pi_load overwrites the digit (last request wins).
- Fetch FSM:
  - IDLE: if pending, go to FETCH.
  - FETCH (1 cycle):
    - po_rom_en=1, po_rom_addr=digit register.
    - Clear pending unless pi_load=1 in this same cycle.
    - Go to WAIT.
  - WAIT (1 cycle): po_rom_en=0. ROM data is valid this cycle. On the closing edge, shadow<=pi_rom_data and shadow_valid<=1. Go to IDLE.
  - po_rom_en is high for exactly one cycle per fetch; it is otherwise 0.
  - po_rom_addr holds its last value outside FETCH.
  - Data is never sampled outside WAIT, because the ROM returns a non-glyph pattern when en=0.
  - Address is passed through unchecked. Codes >9 display whatever the ROM returns.
- po_busy = pending OR state!=IDLE, registered.
- Scan runs continuously from reset release:
  - The divider counts 0..CLK_DIV-1.
  - At divider=CLK_DIV-1 it wraps to 0 and the column index advances k -> k+1 mod 8.
  - On that same edge, po_col<=one-hot(new k) and po_row<=frame[8k+7:8k] for the new k.
  - Byte 0 (LSBs) maps to column 0.
  - The first column update occurs CLK_DIV cycles after reset release. po_col/po_row stay 0 until then.
- Frame swap:
  - On the edge where the column wraps 7 -> 0, po_frame_done<=1 for one cycle.
  - On that edge, if shadow_valid=1: frame<=shadow, shadow_valid<=0, and po_row for column 0 is taken from the new frame.
- Simultaneous events:
  - Shadow capture on the same edge as a swap: the swap uses the old shadow. The new capture sets shadow_valid and swaps at the next boundary.
  - Two fetches completing before one boundary: the later overwrites the shadow. Only the latest glyph is shown.

Test Plan:
- Reset then scan, CLK_DIV=4, no load:
  - po_col first becomes 8'h01 at cycle 4 after reset release, then 02, 04 … 80, 01, each every 4 cycles.
  - po_row=0 throughout.
  - po_frame_done pulses every 32 cycles.
- ROM model with 1-cycle latency; pi_load with pi_digit=0:
  - po_rom_en high exactly 1 cycle with addr 0.
  - po_busy falls after WAIT.
  - After the next frame boundary, po_row over columns 0..7 = 00,00,7e,81,81,81,7e,00.
- pi_load digit 1 mid-frame (column 3):
  - Remaining columns of the current frame still show the old glyph.
  - The swap is seen only at the column-0 edge, with col 3 row = ff.
- Back-to-back pi_load 2 then 3 on consecutive cycles: the displayed glyph after the boundary is digit 3 (bytes 00,00,76,89,89,81,42,00 for columns 0..7), with no tearing.
- pi_load digit 15: addr F issued; the displayed frame is 8142241818244281 (column 0 row = 81, column 3 row = 18).
- Assert pi_rst_n=0 during WAIT: all outputs go 0 asynchronously. After release, there is no ROM access until a new pi_load, and the display is blank.
